lsu: RTL and testbench

Load/store unit sitting directly downstream of the hart's data-memory port. It accepts one byte-addressed load or store request at a time and checks alignment. It drives a word-aligned, masked request into a handshaked data memory with variable latency, then returns sign- or zero-extended load data or a trap indication. Later hart phases use this block in place of the combinational single-cycle dmem access, stalling while `o_req_ready` is low.

---
 rtl/lsu_pkg.sv | 29 ++
 rtl/lsu_align.sv | 55 +++++
 rtl/lsu.sv | 153 +++++++++++++++
 tb/tb_lsu.sv | 382 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings, FSM state type and alignment rule for the load/store unit.
package lsu_pkg;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;
    localparam logic [1:0] SIZE_X = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_ISSUE   = 2'b01,
        ST_WAIT_RD = 2'b10,
        ST_RESP    = 2'b11
    } lsu_state_e;

    // Only the two low address bits decide alignment; illegal size always traps.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr);
        logic bad;
        bad = 1'b0;
        case (size)
            SIZE_B:  bad = 1'b0;
            SIZE_H:  bad = addr[0];
            SIZE_W:  bad = (addr != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: store mask/data placement and load extract/extend.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  st_size_i,
    input  logic [1:0]  st_addr_i,
    input  logic [31:0] st_wdata_i,
    output logic [3:0]  st_mask_o,
    output logic [31:0] st_wdata_o,
    input  logic [1:0]  ld_size_i,
    input  logic [1:0]  ld_addr_i,
    input  logic        ld_unsigned_i,
    input  logic [31:0] ld_rdata_i,
    output logic [31:0] ld_data_o
);

    always_comb begin
        st_mask_o  = 4'b0000;
        st_wdata_o = 32'h0;
        case (st_size_i)
            SIZE_B: begin
                st_mask_o  = 4'b0001 << st_addr_i;
                st_wdata_o = {24'h0, st_wdata_i[7:0]} << {st_addr_i, 3'b000};
            end
            SIZE_H: begin
                st_mask_o  = 4'b0011 << st_addr_i;
                st_wdata_o = {16'h0, st_wdata_i[15:0]} << {st_addr_i[1], 4'b0000};
            end
            SIZE_W: begin
                st_mask_o  = 4'b1111;
                st_wdata_o = st_wdata_i;
            end
            default: begin
                st_mask_o  = 4'b0000;
                st_wdata_o = 32'h0;
            end
        endcase
    end

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        ld_byte   = ld_rdata_i[{ld_addr_i, 3'b000} +: 8];
        ld_half   = ld_rdata_i[{ld_addr_i[1], 4'b0000} +: 16];
        ld_data_o = 32'h0;
        case (ld_size_i)
            SIZE_B:  ld_data_o = ld_unsigned_i ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            SIZE_H:  ld_data_o = ld_unsigned_i ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
            SIZE_W:  ld_data_o = ld_rdata_i;
            default: ld_data_o = 32'h0;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one request at a time, alignment trap, handshaked memory
// issue with variable read latency, registered one-cycle response.
module lsu
    import lsu_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req_valid,
    input  logic        i_req_wen,
    input  logic [31:0] i_req_addr,
    input  logic [1:0]  i_req_size,
    input  logic        i_req_unsigned,
    input  logic [31:0] i_req_wdata,
    output logic        o_req_ready,
    output logic        o_rsp_valid,
    output logic [31:0] o_rsp_rdata,
    output logic        o_rsp_trap,
    output logic [31:0] o_mem_addr,
    output logic        o_mem_ren,
    output logic        o_mem_wen,
    output logic [3:0]  o_mem_mask,
    output logic [31:0] o_mem_wdata,
    input  logic        i_mem_ready,
    input  logic        i_mem_valid,
    input  logic [31:0] i_mem_rdata
);

    lsu_state_e  state_q;
    logic        req_ready_q;
    logic        rsp_valid_q;
    logic        rsp_trap_q;
    logic [31:0] rsp_rdata_q;
    logic [31:0] mem_addr_q;
    logic        mem_ren_q;
    logic        mem_wen_q;
    logic [3:0]  mem_mask_q;
    logic [31:0] mem_wdata_q;
    logic [1:0]  size_q;
    logic [1:0]  addr_lo_q;
    logic        unsigned_q;

    logic [3:0]  st_mask;
    logic [31:0] st_wdata;
    logic [31:0] ld_data;
    logic        req_trap;

    // Store steering works on the live request so the issue registers load
    // already lane-shifted; load extraction works on the latched request.
    lsu_align u_align (
        .st_size_i     (i_req_size),
        .st_addr_i     (i_req_addr[1:0]),
        .st_wdata_i    (i_req_wdata),
        .st_mask_o     (st_mask),
        .st_wdata_o    (st_wdata),
        .ld_size_i     (size_q),
        .ld_addr_i     (addr_lo_q),
        .ld_unsigned_i (unsigned_q),
        .ld_rdata_i    (i_mem_rdata),
        .ld_data_o     (ld_data)
    );

    assign req_trap = misaligned(i_req_size, i_req_addr[1:0]);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_trap_q  <= 1'b0;
            rsp_rdata_q <= 32'h0;
            mem_addr_q  <= 32'h0;
            mem_ren_q   <= 1'b0;
            mem_wen_q   <= 1'b0;
            mem_mask_q  <= 4'b0000;
            mem_wdata_q <= 32'h0;
            size_q      <= SIZE_B;
            addr_lo_q   <= 2'b00;
            unsigned_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_req_valid) begin
                        req_ready_q <= 1'b0;
                        size_q      <= i_req_size;
                        addr_lo_q   <= i_req_addr[1:0];
                        unsigned_q  <= i_req_unsigned;
                        if (req_trap) begin
                            state_q     <= ST_RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_trap_q  <= 1'b1;
                            rsp_rdata_q <= 32'h0;
                        end else begin
                            state_q     <= ST_ISSUE;
                            mem_addr_q  <= {i_req_addr[31:2], 2'b00};
                            mem_mask_q  <= st_mask;
                            mem_wdata_q <= i_req_wen ? st_wdata : 32'h0;
                            mem_ren_q   <= ~i_req_wen;
                            mem_wen_q   <= i_req_wen;
                        end
                    end
                end
                ST_ISSUE: begin
                    // Request fields stay frozen until the memory takes them.
                    if (i_mem_ready) begin
                        mem_addr_q  <= 32'h0;
                        mem_ren_q   <= 1'b0;
                        mem_wen_q   <= 1'b0;
                        mem_mask_q  <= 4'b0000;
                        mem_wdata_q <= 32'h0;
                        if (mem_wen_q) begin
                            state_q     <= ST_RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_trap_q  <= 1'b0;
                            rsp_rdata_q <= 32'h0;
                        end else begin
                            state_q <= ST_WAIT_RD;
                        end
                    end
                end
                ST_WAIT_RD: begin
                    if (i_mem_valid) begin
                        state_q     <= ST_RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_trap_q  <= 1'b0;
                        rsp_rdata_q <= ld_data;
                    end
                end
                ST_RESP: begin
                    state_q     <= ST_IDLE;
                    req_ready_q <= 1'b1;
                    rsp_valid_q <= 1'b0;
                    rsp_trap_q  <= 1'b0;
                    rsp_rdata_q <= 32'h0;
                end
                default: begin
                    state_q     <= ST_IDLE;
                    req_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign o_req_ready = req_ready_q;
    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_trap  = rsp_trap_q;
    assign o_rsp_rdata = rsp_rdata_q;
    assign o_mem_addr  = mem_addr_q;
    assign o_mem_ren   = mem_ren_q;
    assign o_mem_wen   = mem_wen_q;
    assign o_mem_mask  = mem_mask_q;
    assign o_mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_lsu.sv
// Directed and randomized bench for lsu with a behavioral handshaked memory.
module tb_lsu;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_req_valid;
    logic        i_req_wen;
    logic [31:0] i_req_addr;
    logic [1:0]  i_req_size;
    logic        i_req_unsigned;
    logic [31:0] i_req_wdata;
    logic        o_req_ready;
    logic        o_rsp_valid;
    logic [31:0] o_rsp_rdata;
    logic        o_rsp_trap;
    logic [31:0] o_mem_addr;
    logic        o_mem_ren;
    logic        o_mem_wen;
    logic [3:0]  o_mem_mask;
    logic [31:0] o_mem_wdata;
    logic        i_mem_ready;
    logic        i_mem_valid;
    logic [31:0] i_mem_rdata;

    int checks = 0;
    int errors = 0;

    always #5 i_clk = ~i_clk;

    lsu dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_req_valid    (i_req_valid),
        .i_req_wen      (i_req_wen),
        .i_req_addr     (i_req_addr),
        .i_req_size     (i_req_size),
        .i_req_unsigned (i_req_unsigned),
        .i_req_wdata    (i_req_wdata),
        .o_req_ready    (o_req_ready),
        .o_rsp_valid    (o_rsp_valid),
        .o_rsp_rdata    (o_rsp_rdata),
        .o_rsp_trap     (o_rsp_trap),
        .o_mem_addr     (o_mem_addr),
        .o_mem_ren      (o_mem_ren),
        .o_mem_wen      (o_mem_wen),
        .o_mem_mask     (o_mem_mask),
        .o_mem_wdata    (o_mem_wdata),
        .i_mem_ready    (i_mem_ready),
        .i_mem_valid    (i_mem_valid),
        .i_mem_rdata    (i_mem_rdata)
    );

    // Reference model, written per byte lane.
    function automatic logic [3:0] m_mask(input logic [1:0] sz, input logic [1:0] a);
        logic [3:0] m;
        int ai;
        m  = 4'b0000;
        ai = int'(a);
        if (sz == 2'b00) m[ai] = 1'b1;
        else if (sz == 2'b01) begin m[ai] = 1'b1; m[ai + 1] = 1'b1; end
        else if (sz == 2'b10) m = 4'b1111;
        return m;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [1:0] a, input logic [31:0] w);
        logic [31:0] r;
        logic [3:0]  m;
        int lane0;
        r     = 32'h0;
        m     = m_mask(sz, a);
        lane0 = (sz == 2'b10) ? 0 : int'(a);
        for (int i = 0; i < 4; i++)
            if (m[i]) r[8*i +: 8] = w[8*(i - lane0) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_load(input logic [1:0] sz, input logic [1:0] a, input logic uns, input logic [31:0] rw);
        logic [7:0]  b0;
        logic [7:0]  b1;
        int ai;
        ai = int'(a);
        b0 = rw[8*ai +: 8];
        b1 = (ai < 3) ? rw[8*(ai + 1) +: 8] : 8'h00;
        if (sz == 2'b00) return uns ? {24'h0, b0} : {{24{b0[7]}}, b0};
        if (sz == 2'b01) return uns ? {16'h0, b1, b0} : {{16{b1[7]}}, b1, b0};
        return rw;
    endfunction

    // Drives one request and plays the memory side; returns what was observed.
    task automatic txn(input logic wen, input logic [31:0] addr, input logic [1:0] size,
                       input logic uns, input logic [31:0] wdata, input int rdy_dly,
                       input int vld_dly, input logic [31:0] rword, input logic stray,
                       output logic [31:0] r_rdata, output logic r_trap, output int r_cyc,
                       output logic [31:0] r_maddr, output logic [3:0] r_mask,
                       output logic [31:0] r_mwdata, output logic r_saw_mem,
                       output logic r_both, output logic r_unstable);
        int cyc, icnt, wcnt;
        logic accepted, done, first;
        r_rdata = 32'h0; r_trap = 1'b0; r_cyc = -1;
        r_maddr = 32'h0; r_mask = 4'h0; r_mwdata = 32'h0;
        r_saw_mem = 1'b0; r_both = 1'b0; r_unstable = 1'b0;
        i_req_valid = 1'b1; i_req_wen = wen; i_req_addr = addr; i_req_size = size;
        i_req_unsigned = uns; i_req_wdata = wdata;
        i_mem_ready = 1'b0; i_mem_valid = 1'b0;
        cyc = 0; icnt = 0; wcnt = 0; accepted = 1'b0; done = 1'b0; first = 1'b1;
        while (!done && cyc < 60) begin
            @(negedge i_clk);
            cyc++;
            i_req_valid = 1'b0;
            i_mem_ready = 1'b0;
            i_mem_valid = 1'b0;
            i_mem_rdata = 32'h5A5A_A5A5;
            if (o_mem_ren && o_mem_wen) r_both = 1'b1;
            if (o_rsp_valid) begin
                r_rdata = o_rsp_rdata; r_trap = o_rsp_trap; r_cyc = cyc; done = 1'b1;
            end else if (o_mem_ren || o_mem_wen) begin
                r_saw_mem = 1'b1;
                if (first) begin
                    r_maddr = o_mem_addr; r_mask = o_mem_mask; r_mwdata = o_mem_wdata; first = 1'b0;
                end else if (o_mem_addr !== r_maddr || o_mem_mask !== r_mask || o_mem_wdata !== r_mwdata) begin
                    r_unstable = 1'b1;
                end
                if (icnt == rdy_dly) begin i_mem_ready = 1'b1; accepted = 1'b1; end
                icnt++;
                if (stray) begin i_mem_valid = 1'b1; i_mem_rdata = ~rword; end
            end else if (accepted && !wen) begin
                if (wcnt == vld_dly) begin i_mem_valid = 1'b1; i_mem_rdata = rword; end
                wcnt++;
            end
        end
        i_mem_ready = 1'b0;
        i_mem_valid = 1'b0;
    endtask

    logic [31:0] g_rdata, g_maddr, g_mwdata;
    logic [3:0]  g_mask;
    logic        g_trap, g_saw, g_both, g_unst;
    int          g_cyc;

    task automatic test_reset();
        i_rst = 1'b1;
        i_req_valid = 1'b0; i_req_wen = 1'b0; i_req_addr = 32'h0; i_req_size = 2'b00;
        i_req_unsigned = 1'b0; i_req_wdata = 32'h0;
        i_mem_ready = 1'b0; i_mem_valid = 1'b0; i_mem_rdata = 32'h0;
        repeat (2) @(negedge i_clk);
        checks++;
        if ({o_req_ready, o_rsp_valid, o_rsp_trap, o_mem_ren, o_mem_wen} !== 5'b10000 ||
            o_rsp_rdata !== 32'h0 || o_mem_addr !== 32'h0 || o_mem_mask !== 4'h0 || o_mem_wdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_during: ready=%b rsp=%b trap=%b ren=%b wen=%b, required ready=1 rest 0",
                     o_req_ready, o_rsp_valid, o_rsp_trap, o_mem_ren, o_mem_wen);
        end
        i_rst = 1'b0;
        @(negedge i_clk);
        checks++;
        if ({o_req_ready, o_rsp_valid, o_rsp_trap, o_mem_ren, o_mem_wen} !== 5'b10000 ||
            o_rsp_rdata !== 32'h0 || o_mem_mask !== 4'h0) begin
            errors++;
            $display("FAIL reset_after: ready=%b rsp=%b ren=%b wen=%b, required ready=1 rest 0",
                     o_req_ready, o_rsp_valid, o_mem_ren, o_mem_wen);
        end
    endtask

    task automatic test_store();
        txn(1'b1, 32'h0000_2003, 2'b00, 1'b0, 32'h0000_00AB, 0, 0, 32'h0, 1'b0,
            g_rdata, g_trap, g_cyc, g_maddr, g_mask, g_mwdata, g_saw, g_both, g_unst);
        checks++;
        if (g_maddr !== 32'h2000 || g_mask !== 4'b1000 || g_mwdata !== 32'hAB00_0000) begin
            errors++;
            $display("FAIL sb_issue: addr=%h mask=%b wdata=%h, required 00002000 1000 ab000000", g_maddr, g_mask, g_mwdata);
        end
        checks++;
        if (g_cyc !== 2 || g_trap !== 1'b0 || g_rdata !== 32'h0) begin
            errors++;
            $display("FAIL sb_rsp: cycle=%0d trap=%b rdata=%h, required 2 0 00000000", g_cyc, g_trap, g_rdata);
        end
        @(negedge i_clk);
        txn(1'b1, 32'h0000_2002, 2'b01, 1'b0, 32'h1234_5678, 1, 0, 32'h0, 1'b0,
            g_rdata, g_trap, g_cyc, g_maddr, g_mask, g_mwdata, g_saw, g_both, g_unst);
        checks++;
        if (g_mask !== 4'b1100 || g_mwdata !== 32'h5678_0000 || g_cyc !== 3 || g_unst !== 1'b0) begin
            errors++;
            $display("FAIL sh_issue: mask=%b wdata=%h cycle=%0d unstable=%b, required 1100 56780000 3 0",
                     g_mask, g_mwdata, g_cyc, g_unst);
        end
        @(negedge i_clk);
    endtask

    task automatic test_load_half();
        txn(1'b0, 32'h0000_1002, 2'b01, 1'b0, 32'h0, 3, 1, 32'h8001_FFFF, 1'b1,
            g_rdata, g_trap, g_cyc, g_maddr, g_mask, g_mwdata, g_saw, g_both, g_unst);
        checks++;
        if (g_rdata !== 32'hFFFF_8001 || g_trap !== 1'b0 || g_cyc !== 7) begin
            errors++;
            $display("FAIL lh: rdata=%h trap=%b cycle=%0d, required ffff8001 0 7", g_rdata, g_trap, g_cyc);
        end
        checks++;
        if (g_maddr !== 32'h1000 || g_mask !== 4'b1100 || g_unst !== 1'b0) begin
            errors++;
            $display("FAIL lh_issue: addr=%h mask=%b unstable=%b, required 00001000 1100 0", g_maddr, g_mask, g_unst);
        end
        @(negedge i_clk);
        txn(1'b0, 32'h0000_1002, 2'b01, 1'b1, 32'h0, 3, 1, 32'h8001_FFFF, 1'b0,
            g_rdata, g_trap, g_cyc, g_maddr, g_mask, g_mwdata, g_saw, g_both, g_unst);
        checks++;
        if (g_rdata !== 32'h0000_8001) begin
            errors++;
            $display("FAIL lhu: rdata=%h, required 00008001", g_rdata);
        end
        @(negedge i_clk);
        txn(1'b0, 32'h0000_1000, 2'b10, 1'b0, 32'h0, 0, 0, 32'hCAFE_F00D, 1'b0,
            g_rdata, g_trap, g_cyc, g_maddr, g_mask, g_mwdata, g_saw, g_both, g_unst);
        checks++;
        if (g_rdata !== 32'hCAFE_F00D || g_cyc !== 3 || g_mask !== 4'b1111) begin
            errors++;
            $display("FAIL lw_min_latency: rdata=%h cycle=%0d mask=%b, required cafef00d 3 1111", g_rdata, g_cyc, g_mask);
        end
        @(negedge i_clk);
    endtask

    task automatic test_trap();
        txn(1'b0, 32'h0000_1001, 2'b10, 1'b0, 32'h0, 0, 0, 32'h0, 1'b0,
            g_rdata, g_trap, g_cyc, g_maddr, g_mask, g_mwdata, g_saw, g_both, g_unst);
        checks++;
        if (g_trap !== 1'b1 || g_cyc !== 1 || g_saw !== 1'b0 || g_rdata !== 32'h0) begin
            errors++;
            $display("FAIL lw_misaligned: trap=%b cycle=%0d mem_seen=%b rdata=%h, required 1 1 0 0", g_trap, g_cyc, g_saw, g_rdata);
        end
        @(negedge i_clk);
        txn(1'b0, 32'h0000_1000, 2'b11, 1'b0, 32'h0, 0, 0, 32'h0, 1'b0,
            g_rdata, g_trap, g_cyc, g_maddr, g_mask, g_mwdata, g_saw, g_both, g_unst);
        checks++;
        if (g_trap !== 1'b1 || g_cyc !== 1 || g_saw !== 1'b0) begin
            errors++;
            $display("FAIL size_illegal: trap=%b cycle=%0d mem_seen=%b, required 1 1 0", g_trap, g_cyc, g_saw);
        end
        @(negedge i_clk);
        txn(1'b1, 32'h0000_1003, 2'b01, 1'b0, 32'hFFFF_FFFF, 0, 0, 32'h0, 1'b0,
            g_rdata, g_trap, g_cyc, g_maddr, g_mask, g_mwdata, g_saw, g_both, g_unst);
        checks++;
        if (g_trap !== 1'b1 || g_cyc !== 1 || g_saw !== 1'b0) begin
            errors++;
            $display("FAIL sh_misaligned: trap=%b cycle=%0d mem_seen=%b, required 1 1 0", g_trap, g_cyc, g_saw);
        end
        @(negedge i_clk);
    endtask

    task automatic test_load_byte();
        txn(1'b0, 32'h0000_3001, 2'b00, 1'b0, 32'h0, 0, 0, 32'h0000_7F80, 1'b0,
            g_rdata, g_trap, g_cyc, g_maddr, g_mask, g_mwdata, g_saw, g_both, g_unst);
        checks++;
        if (g_rdata !== 32'h0000_007F || g_mask !== 4'b0010) begin
            errors++;
            $display("FAIL lb_3001: rdata=%h mask=%b, required 0000007f 0010", g_rdata, g_mask);
        end
        @(negedge i_clk);
        txn(1'b0, 32'h0000_3000, 2'b00, 1'b0, 32'h0, 0, 0, 32'h0000_7F80, 1'b0,
            g_rdata, g_trap, g_cyc, g_maddr, g_mask, g_mwdata, g_saw, g_both, g_unst);
        checks++;
        if (g_rdata !== 32'hFFFF_FF80) begin
            errors++;
            $display("FAIL lb_sign: rdata=%h, required ffffff80", g_rdata);
        end
        @(negedge i_clk);
        txn(1'b0, 32'h0000_3000, 2'b00, 1'b1, 32'h0, 0, 0, 32'h0000_7F80, 1'b0,
            g_rdata, g_trap, g_cyc, g_maddr, g_mask, g_mwdata, g_saw, g_both, g_unst);
        checks++;
        if (g_rdata !== 32'h0000_0080) begin
            errors++;
            $display("FAIL lbu: rdata=%h, required 00000080", g_rdata);
        end
    endtask

    task automatic test_back_to_back();
        // Response cycle of the previous lbu: unit must not be ready yet.
        checks++;
        if (o_req_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_in_resp: ready=%b, required 0", o_req_ready);
        end
        i_req_valid = 1'b1; i_req_wen = 1'b0; i_req_addr = 32'h0000_3004;
        i_req_size = 2'b10; i_req_unsigned = 1'b0;
        @(negedge i_clk);
        i_req_valid = 1'b0;
        checks++;
        if (o_req_ready !== 1'b1 || o_mem_ren !== 1'b0 || o_rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL req_during_resp: ready=%b ren=%b rsp=%b, required 1 0 0", o_req_ready, o_mem_ren, o_rsp_valid);
        end
        txn(1'b0, 32'h0000_3001, 2'b00, 1'b0, 32'h0, 0, 0, 32'h0000_7F80, 1'b0,
            g_rdata, g_trap, g_cyc, g_maddr, g_mask, g_mwdata, g_saw, g_both, g_unst);
        checks++;
        if (g_rdata !== 32'h0000_007F || g_cyc !== 3) begin
            errors++;
            $display("FAIL b2b_lb: rdata=%h cycle=%0d, required 0000007f 3", g_rdata, g_cyc);
        end
        @(negedge i_clk);
    endtask

    task automatic test_reset_mid();
        logic seen;
        i_req_valid = 1'b1; i_req_wen = 1'b0; i_req_addr = 32'h0000_4000;
        i_req_size = 2'b10; i_req_unsigned = 1'b0;
        @(negedge i_clk);
        i_req_valid = 1'b0;
        i_mem_ready = 1'b1;
        @(negedge i_clk);
        i_mem_ready = 1'b0;
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        i_mem_valid = 1'b1; i_mem_rdata = 32'h1111_2222;
        seen = 1'b0;
        repeat (3) begin
            @(negedge i_clk);
            if (o_rsp_valid) seen = 1'b1;
        end
        i_mem_valid = 1'b0;
        checks++;
        if (seen !== 1'b0 || o_req_ready !== 1'b1 || o_mem_ren !== 1'b0 || o_rsp_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid: rsp_seen=%b ready=%b ren=%b rdata=%h, required 0 1 0 0",
                     seen, o_req_ready, o_mem_ren, o_rsp_rdata);
        end
    endtask

    task automatic test_random();
        logic [31:0] r, addr, wdata, rword;
        logic [1:0]  sz;
        logic        wen, uns, exp_trap;
        int          rd, vd, exp_cyc;
        for (int n = 0; n < 40; n++) begin
            r = $urandom; addr = $urandom; wdata = $urandom; rword = $urandom;
            sz = r[1:0]; wen = r[2]; uns = r[3];
            rd = int'(r[5:4]); vd = int'(r[7:6]);
            exp_trap = (sz == 2'b11) || (sz == 2'b01 && addr[0]) || (sz == 2'b10 && addr[1:0] != 2'b00);
            exp_cyc  = exp_trap ? 1 : (wen ? 2 + rd : 3 + rd + vd);
            txn(wen, addr, sz, uns, wdata, rd, vd, rword, r[8],
                g_rdata, g_trap, g_cyc, g_maddr, g_mask, g_mwdata, g_saw, g_both, g_unst);
            checks++;
            if (g_trap !== exp_trap || g_cyc !== exp_cyc || g_both !== 1'b0 || g_unst !== 1'b0) begin
                errors++;
                $display("FAIL rand_ctl[%0d]: trap=%b cycle=%0d both=%b unstable=%b, required %b %0d 0 0",
                         n, g_trap, g_cyc, g_both, g_unst, exp_trap, exp_cyc);
            end
            checks++;
            if (exp_trap || wen) begin
                if (g_rdata !== 32'h0) begin
                    errors++;
                    $display("FAIL rand_rdata[%0d]: rdata=%h, required 00000000", n, g_rdata);
                end
            end else if (g_rdata !== m_load(sz, addr[1:0], uns, rword)) begin
                errors++;
                $display("FAIL rand_rdata[%0d]: rdata=%h, required %h", n, g_rdata, m_load(sz, addr[1:0], uns, rword));
            end
            if (!exp_trap) begin
                checks++;
                if (g_maddr !== {addr[31:2], 2'b00} || g_mask !== m_mask(sz, addr[1:0]) ||
                    g_mwdata !== (wen ? m_wdata(sz, addr[1:0], wdata) : 32'h0)) begin
                    errors++;
                    $display("FAIL rand_issue[%0d]: addr=%h mask=%b wdata=%h, required %h %b %h", n, g_maddr, g_mask, g_mwdata,
                             {addr[31:2], 2'b00}, m_mask(sz, addr[1:0]), wen ? m_wdata(sz, addr[1:0], wdata) : 32'h0);
                end
            end
            @(negedge i_clk);
        end
    endtask

    initial begin
        test_reset();
        test_store();
        test_load_half();
        test_trap();
        test_load_byte();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
